// File: rtl/regfile_pkg.sv
// regfile_pkg -- shared constants for the register file slice.
//   DEFAULT_DATA_W : default register data width
//   DEFAULT_ADDR_W : default register address width (depth = 2**ADDR_W)
//   REG_ZERO       : address of the hard-wired zero register
package regfile_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_ADDR_W = 5;
  localparam int REG_ZERO       = 0;

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard -- one pending bit per architectural register.
// Ports:
//   clock    : rising-edge clock
//   reset    : synchronous active-high reset, clears every bit
//   set_en   : instruction issue marks set_addr as having a write in flight
//   set_addr : register to mark pending
//   clr_en   : writeback retires the write to clr_addr
//   clr_addr : register to clear
//   busy     : registered pending-bit vector, bit 0 is always 0
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 set_en,
  input  logic [ADDR_W-1:0]    set_addr,
  input  logic                 clr_en,
  input  logic [ADDR_W-1:0]    clr_addr,
  output logic [2**ADDR_W-1:0] busy
);

  localparam int                DEPTH     = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic [DEPTH-1:0] busy_r;
  logic [DEPTH-1:0] busy_nxt_s;

  // Next-state: clear first, then set, so a same-cycle issue to the
  // register being written back leaves it pending.
  always_comb begin
    busy_nxt_s = busy_r;
    if (clr_en) begin
      busy_nxt_s[clr_addr] = 1'b0;
    end else begin
      busy_nxt_s[clr_addr] = busy_r[clr_addr];
    end
    if (set_en && (set_addr != ZERO_ADDR)) begin
      busy_nxt_s[set_addr] = 1'b1;
    end else begin
      busy_nxt_s[set_addr] = busy_nxt_s[set_addr];
    end
    busy_nxt_s[REG_ZERO] = 1'b0;
  end

  // Pending-bit state register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      busy_r <= {DEPTH{1'b0}};
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  assign busy = busy_r;

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb -- multi-read-port register file with a write scoreboard.
// Ports:
//   clock     : rising-edge clock
//   reset     : synchronous active-high reset (registers and scoreboard to 0)
//   we        : writeback write enable
//   waddr     : writeback destination register
//   wdata     : writeback data
//   raddr     : packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rdata     : packed combinational read data, same packing
//   busy_set  : issue of an instruction that will write busy_addr
//   busy_addr : register being marked pending
//   pending   : bit i set when read port i targets a pending register
//   stall     : OR of all pending bits
// Build option: define REGFILE_BYPASS_EN to forward same-cycle writeback
// data to matching read ports (and mask their pending bit). Without it a
// colliding read sees the pre-write value.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int NREAD  = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    we,
  input  logic [ADDR_W-1:0]       waddr,
  input  logic [DATA_W-1:0]       wdata,
  input  logic [NREAD*ADDR_W-1:0] raddr,
  output logic [NREAD*DATA_W-1:0] rdata,
  input  logic                    busy_set,
  input  logic [ADDR_W-1:0]       busy_addr,
  output logic [NREAD-1:0]        pending,
  output logic                    stall
);

  localparam int                DEPTH     = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DEPTH-1:0]  busy_s;
  logic [ADDR_W-1:0] port_addr_s [NREAD];
  logic [NREAD-1:0]  bypass_hit_s;

  regfile_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clock    (clock),
    .reset    (reset),
    .set_en   (busy_set),
    .set_addr (busy_addr),
    .clr_en   (we),
    .clr_addr (waddr),
    .busy     (busy_s)
  );

  // Register storage; register 0 is never written so it stays 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else if (we && (waddr != ZERO_ADDR)) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Per-port read mux and pending lookup, fully independent per port.
  always_comb begin
    rdata   = {(NREAD*DATA_W){1'b0}};
    pending = {NREAD{1'b0}};
    for (int i = 0; i < NREAD; i++) begin
      port_addr_s[i] = raddr[i*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
      bypass_hit_s[i] = we && (waddr != ZERO_ADDR) && (port_addr_s[i] == waddr);
`else
      bypass_hit_s[i] = 1'b0;
`endif
      if (bypass_hit_s[i]) begin
        rdata[i*DATA_W +: DATA_W] = wdata;
        pending[i]                = 1'b0;
      end else if (port_addr_s[i] == ZERO_ADDR) begin
        rdata[i*DATA_W +: DATA_W] = {DATA_W{1'b0}};
        pending[i]                = 1'b0;
      end else begin
        rdata[i*DATA_W +: DATA_W] = mem_r[port_addr_s[i]];
        pending[i]                = busy_s[port_addr_s[i]];
      end
    end
  end

  assign stall = |pending;

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

  logic        clock;
  logic        reset;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic        busy_set;
  logic [4:0]  busy_addr;
  logic [1:0]  pending;
  logic        stall;

  int total = 0;
  int bad   = 0;

  // Reference model: architectural register values and pending flags.
  logic [31:0] m_regs [32];
  bit          m_sb   [32];

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .NREAD(2)) dut (
    .clock     (clock),
    .reset     (reset),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .raddr     (raddr),
    .rdata     (rdata),
    .busy_set  (busy_set),
    .busy_addr (busy_addr),
    .pending   (pending),
    .stall     (stall)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic w, input logic [4:0] wa,
                       input logic [31:0] wd, input logic bs, input logic [4:0] ba,
                       input logic [4:0] r0, input logic [4:0] r1);
    reset = rst; we = w; waddr = wa; wdata = wd;
    busy_set = bs; busy_addr = ba; raddr = {r1, r0};
    #2;
  endtask

  // Compare every output against the model for the current inputs.
  task automatic check_all(input string tag);
    logic [4:0]  a;
    logic [31:0] er;
    logic        ep;
    logic        any;
    any = 1'b0;
    for (int p = 0; p < 2; p++) begin
      a = raddr[p*5 +: 5];
      if (BYPASS && we && waddr != 5'd0 && waddr == a) begin
        er = wdata; ep = 1'b0;
      end else if (a == 5'd0) begin
        er = 32'd0; ep = 1'b0;
      end else begin
        er = m_regs[a]; ep = m_sb[a];
      end
      any = any | ep;
      chk($sformatf("%s.rdata%0d", tag, p), {32'd0, rdata[p*32 +: 32]}, {32'd0, er});
      chk($sformatf("%s.pend%0d", tag, p), {63'd0, pending[p]}, {63'd0, ep});
    end
    chk({tag, ".stall"}, {63'd0, stall}, {63'd0, any});
  endtask

  // Clock edge plus model update from the inputs seen at that edge.
  task automatic tick();
    @(posedge clock);
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = 32'd0;
        m_sb[i]   = 1'b0;
      end
    end else begin
      if (we && waddr != 5'd0) m_regs[waddr] = wdata;
      if (we) m_sb[waddr] = 1'b0;
      if (busy_set && busy_addr != 5'd0) m_sb[busy_addr] = 1'b1;
    end
    #1;
  endtask

  function automatic logic [4:0] rnd_addr();
    if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'd0;
      m_sb[i]   = 1'b0;
    end
    drive(1'b1, 1'b1, 5'd3, 32'h1234, 1'b1, 5'd4, 5'd0, 5'd0);
    tick();

    // Reset state
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd4);
    check_all("rst");
    chk("rst.rdata", rdata, 64'd0);
    chk("rst.pending", {62'd0, pending}, 64'd0);

    // Reset one cycle after writing r16
    drive(1'b0, 1'b1, 5'd16, 32'hF0, 1'b0, 5'd0, 5'd16, 5'd0);
    tick();
    drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd16, 5'd16, 5'd0);
    chk("r16.before_rst", {32'd0, rdata[31:0]}, 64'hF0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd16, 5'd16);
    check_all("r16rst");
    chk("r16rst.rdata0", {32'd0, rdata[31:0]}, 64'd0);
    chk("r16rst.pending", {62'd0, pending}, 64'd0);

    // Two writes then dual-port read
    drive(1'b0, 1'b1, 5'd8, 32'h20, 1'b0, 5'd0, 5'd0, 5'd0);
    tick();
    drive(1'b0, 1'b1, 5'd9, 32'h27, 1'b0, 5'd0, 5'd0, 5'd0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd8, 5'd9);
    check_all("r8r9");
    chk("r8r9.rdata", rdata, {32'h27, 32'h20});
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd9);
    chk("same_addr.rdata", rdata, {32'h27, 32'h27});

    // Register 0 write and busy_set ignored
    drive(1'b0, 1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 5'd0, 5'd0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    check_all("r0");
    chk("r0.rdata0", {32'd0, rdata[31:0]}, 64'd0);
    chk("r0.pending", {62'd0, pending}, 64'd0);

    // Scoreboard set then cleared by writeback
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd16, 5'd0, 5'd0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd16, 5'd8);
    check_all("sb16");
    chk("sb16.pend0", {63'd0, pending[0]}, 64'd1);
    chk("sb16.stall", {63'd0, stall}, 64'd1);
    drive(1'b0, 1'b1, 5'd16, 32'hF0, 1'b0, 5'd0, 5'd8, 5'd8);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd16, 5'd8);
    check_all("wb16");
    chk("wb16.pending", {62'd0, pending}, 64'd0);
    chk("wb16.rdata0", {32'd0, rdata[31:0]}, 64'hF0);

    // Simultaneous issue and writeback to r10
    drive(1'b0, 1'b1, 5'd10, 32'h5, 1'b1, 5'd10, 5'd0, 5'd0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd10, 5'd0);
    check_all("r10");
    chk("r10.rdata0", {32'd0, rdata[31:0]}, 64'h5);
    chk("r10.pend0", {63'd0, pending[0]}, 64'd1);

    // Same-cycle read/write collision on r12
    drive(1'b0, 1'b1, 5'd12, 32'h11, 1'b0, 5'd0, 5'd0, 5'd0);
    tick();
    drive(1'b0, 1'b1, 5'd12, 32'h77, 1'b0, 5'd0, 5'd12, 5'd12);
    check_all("byp12");
    chk("byp12.rdata0", {32'd0, rdata[31:0]}, BYPASS ? 64'h77 : 64'h11);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd12, 5'd0);
    chk("byp12.after", {32'd0, rdata[31:0]}, 64'h77);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)), rnd_addr(),
            $urandom(), 1'($urandom_range(0, 1)), rnd_addr(), rnd_addr(), rnd_addr());
      check_all($sformatf("rnd%0d", n));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
